// File: rtl/reg_select_decoder.sv
// reg_select_decoder
// Sequenced 5-to-32 register-select decoder. Turns a register index into a
// registered one-hot enable for the register file. Single mode issues one
// enable; sweep mode walks the index from idx_a to idx_b (inclusive, modulo
// NREG), one enable per cycle, for register dump/clear sequences.
//
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   i_start    request a new operation (sampled only in idle)
//   i_sweep    0 = single, 1 = sweep (sampled with start)
//   i_idx_a    single index / sweep start index (sampled with start)
//   i_idx_b    sweep end index, inclusive (sampled with start)
//   i_abort    synchronous abort, back to idle with no done pulse
//   o_en_out   registered one-hot enable, zero when not issuing
//   o_idx_out  index currently on o_en_out, holds last value otherwise
//   o_busy     high while issuing and in the done cycle
//   o_done     one-cycle completion pulse
module reg_select_decoder #(
    parameter int unsigned NREG = 32,
    parameter int unsigned IDXW = 5
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic            i_sweep,
    input  logic [IDXW-1:0] i_idx_a,
    input  logic [IDXW-1:0] i_idx_b,
    input  logic            i_abort,
    output logic [NREG-1:0] o_en_out,
    output logic [IDXW-1:0] o_idx_out,
    output logic            o_busy,
    output logic            o_done
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_e;

    localparam logic [NREG-1:0] OneHotBase = {{(NREG - 1){1'b0}}, 1'b1};

    state_e          r_state;
    logic [IDXW-1:0] r_cur;
    logic [IDXW-1:0] r_end;
    logic [NREG-1:0] r_en_out;
    logic [IDXW-1:0] r_idx_out;
    logic            r_busy;
    logic            r_done;

    state_e          w_state_d;
    logic [IDXW-1:0] w_cur_d;
    logic [IDXW-1:0] w_end_d;
    logic [NREG-1:0] w_en_d;
    logic [IDXW-1:0] w_idx_d;
    logic            w_busy_d;
    logic            w_done_d;
    logic [IDXW-1:0] w_cur_nxt;

    // NREG == 2**IDXW, so the natural IDXW-bit wrap gives the modulo-NREG step.
    assign w_cur_nxt = r_cur + IDXW'(1);

    // Outputs are computed one cycle ahead so that they come straight from flops.
    always_comb begin
        w_state_d = r_state;
        w_cur_d   = r_cur;
        w_end_d   = r_end;
        w_en_d    = '0;
        w_idx_d   = r_idx_out;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!i_abort && i_start) begin
                    w_state_d = StIssue;
                    w_cur_d   = i_idx_a;
                    // Single mode is a sweep whose end equals its start.
                    w_end_d   = i_sweep ? i_idx_b : i_idx_a;
                    w_en_d    = OneHotBase << i_idx_a;
                    w_idx_d   = i_idx_a;
                    w_busy_d  = 1'b1;
                end
            end
            StIssue: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (r_cur == r_end) begin
                    w_state_d = StDone;
                    w_busy_d  = 1'b1;
                    w_done_d  = 1'b1;
                end else begin
                    w_cur_d  = w_cur_nxt;
                    w_en_d   = OneHotBase << w_cur_nxt;
                    w_idx_d  = w_cur_nxt;
                    w_busy_d = 1'b1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= StIdle;
            r_cur     <= '0;
            r_end     <= '0;
            r_en_out  <= '0;
            r_idx_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cur     <= w_cur_d;
            r_end     <= w_end_d;
            r_en_out  <= w_en_d;
            r_idx_out <= w_idx_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
        end
    end

    assign o_en_out  = r_en_out;
    assign o_idx_out = r_idx_out;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_reg_select_decoder.sv
// Testbench for reg_select_decoder. Stimulus pushes the expected per-cycle
// response of each busy cycle into a queue; an independent monitor pops and
// compares one entry for every cycle the DUT reports busy, and checks the
// idle/reset output values otherwise.
module tb_reg_select_decoder;

    typedef struct packed {
        logic [31:0] en;
        logic [4:0]  idx;
        logic        done;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        sweep;
    logic [4:0]  idx_a;
    logic [4:0]  idx_b;
    logic        abort;
    logic [31:0] en_out;
    logic [4:0]  idx_out;
    logic        busy;
    logic        done;

    exp_t        exp_q[$];
    logic [4:0]  last_idx;
    int          n_checks;
    int          n_fail;

    reg_select_decoder #(
        .NREG(32),
        .IDXW(5)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_start   (start),
        .i_sweep   (sweep),
        .i_idx_a   (idx_a),
        .i_idx_b   (idx_b),
        .i_abort   (abort),
        .o_en_out  (en_out),
        .o_idx_out (idx_out),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [31:0] en, input logic [4:0] idx, input logic dn);
        exp_t e;
        e.en   = en;
        e.idx  = idx;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        n_checks++;
        if (!reset_n) begin
            if (en_out !== 32'h0 || idx_out !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: en=%h idx=%0d busy=%b done=%b, required all zero",
                         en_out, idx_out, busy, done);
            end
        end else if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_busy: en=%h idx=%0d done=%b, required idle",
                         en_out, idx_out, done);
            end else begin
                e = exp_q.pop_front();
                last_idx = e.idx;
                if (en_out !== e.en || idx_out !== e.idx || done !== e.done) begin
                    n_fail++;
                    $display("FAIL busy_cycle: en=%h idx=%0d done=%b, required en=%h idx=%0d done=%b",
                             en_out, idx_out, done, e.en, e.idx, e.done);
                end
            end
        end else begin
            if (en_out !== 32'h0 || done !== 1'b0 || idx_out !== last_idx) begin
                n_fail++;
                $display("FAIL idle_outputs: en=%h idx=%0d done=%b, required en=0 idx=%0d done=0",
                         en_out, idx_out, done, last_idx);
            end
        end
    end

    // Waits (bounded) at falling edges until busy drops, then checks that every
    // expected busy cycle was consumed.
    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (busy === 1'b1) begin
            n_fail++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, cyc);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expect: %0d busy cycles missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at a falling edge with the DUT idle.
    task automatic issue(input logic sw, input logic [4:0] a, input logic [4:0] b);
        start = 1'b1;
        sweep = sw;
        idx_a = a;
        idx_b = b;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_idx = 5'd0;
        reset_n  = 1'b0;
        start    = 1'b1;
        sweep    = 1'b0;
        idx_a    = 5'd5;
        idx_b    = 5'd9;
        abort    = 1'b0;

        // Reset held with start asserted, then idle with start low.
        repeat (4) @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single mode, every index.
        for (int i = 0; i < 32; i++) begin
            push_exp(32'd1 << i, 5'(i), 1'b0);
            push_exp(32'h0, 5'(i), 1'b1);
            issue(1'b0, 5'(i), 5'(31 - i));
        end

        // Sweep without wrap.
        push_exp(32'h08, 5'd3, 1'b0);
        push_exp(32'h10, 5'd4, 1'b0);
        push_exp(32'h20, 5'd5, 1'b0);
        push_exp(32'h40, 5'd6, 1'b0);
        push_exp(32'h00, 5'd6, 1'b1);
        issue(1'b1, 5'd3, 5'd6);

        // Sweep with wrap.
        push_exp(32'h4000_0000, 5'd30, 1'b0);
        push_exp(32'h8000_0000, 5'd31, 1'b0);
        push_exp(32'h0000_0001, 5'd0, 1'b0);
        push_exp(32'h0000_0002, 5'd1, 1'b0);
        push_exp(32'h0000_0000, 5'd1, 1'b1);
        issue(1'b1, 5'd30, 5'd1);

        // Full range.
        for (int i = 0; i < 32; i++) push_exp(32'd1 << i, 5'(i), 1'b0);
        push_exp(32'h0, 5'd31, 1'b1);
        issue(1'b1, 5'd0, 5'd31);

        // Equal indices in sweep mode.
        push_exp(32'h200, 5'd9, 1'b0);
        push_exp(32'h000, 5'd9, 1'b1);
        issue(1'b1, 5'd9, 5'd9);

        // Abort in the 5th ISSUE cycle of a full sweep: no done, no further cycles.
        for (int i = 0; i < 5; i++) push_exp(32'd1 << i, 5'(i), 1'b0);
        start = 1'b1;
        sweep = 1'b1;
        idx_a = 5'd0;
        idx_b = 5'd31;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        // Inputs changed while busy are ignored.
        push_exp(32'h08, 5'd3, 1'b0);
        push_exp(32'h10, 5'd4, 1'b0);
        push_exp(32'h20, 5'd5, 1'b0);
        push_exp(32'h40, 5'd6, 1'b0);
        push_exp(32'h00, 5'd6, 1'b1);
        start = 1'b1;
        sweep = 1'b1;
        idx_a = 5'd3;
        idx_b = 5'd6;
        @(negedge clk);
        start = 1'b0;
        sweep = 1'b0;
        idx_a = 5'd20;
        idx_b = 5'd25;
        @(negedge clk);
        start = 1'b1;
        idx_a = 5'd11;
        @(negedge clk);
        start = 1'b0;
        idx_a = 5'd1;
        wait_idle();

        // Asynchronous reset during a sweep.
        for (int i = 0; i < 3; i++) push_exp(32'd1 << (i + 10), 5'(i + 10), 1'b0);
        start = 1'b1;
        sweep = 1'b1;
        idx_a = 5'd10;
        idx_b = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        exp_q.delete();
        last_idx = 5'd0;
        reset_n  = 1'b0;
        #1;
        n_checks++;
        if (en_out !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_en: en=%h, required 0", en_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_busy: busy=%b, required 0", busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // First start straight after reset release.
        push_exp(32'h80, 5'd7, 1'b0);
        push_exp(32'h00, 5'd7, 1'b1);
        issue(1'b0, 5'd7, 5'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_select_decoder.md
# reg_select_decoder

Sequenced 5-to-32 register-select decoder for the CPU datapath. It turns a register index into a registered one-hot enable vector that drives the register file's 32 per-register enables. It is the counterpart of the 32-to-5 bus-select encoder. Two modes: single-register select, or a sweep that asserts each register enable in turn over an index range, used for register dump and clear sequences.

## Interface
- NREG, 32, number of registers / width of the one-hot enable vector
- IDXW, 5, register index width (2^IDXW = NREG)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- sweep  in  1  mode, sampled with start: 0 = single, 1 = sweep
- idx_a  in  IDXW  single-mode index / sweep start index; sampled with start
- idx_b  in  IDXW  sweep end index (inclusive); sampled with start; ignored in single mode
- abort  in  1  synchronous abort; returns to IDLE with no done pulse
- en_out  out  NREG  registered one-hot register enable; all zeros when not issuing
- idx_out  out  IDXW  index currently asserted on en_out; holds its last value otherwise
- busy  out  1  high in ISSUE and DONE
- done  out  1  one-cycle pulse in the DONE state

## Operation
- States: IDLE, ISSUE, DONE. Encoding is free.
- Reset (async, reset_n=0):
  - state=IDLE
  - en_out=0, idx_out=0, busy=0, done=0
  - internal current index and end index cleared to 0
- IDLE:
  - start=1 latches sweep, idx_a and idx_b, and moves to ISSUE.
  - start=0 stays in IDLE.
- ISSUE:
  - en_out = 1 << cur and idx_out = cur, where cur is the current index.
  - Exactly one bit of en_out is set in every ISSUE cycle.
- Single mode: one ISSUE cycle with cur=idx_a, then DONE.
- Sweep mode:
  - cur starts at idx_a and advances by 1 each cycle, modulo NREG.
  - The ISSUE cycle with cur==idx_b is the last one; the next state is DONE.
  - Number of ISSUE cycles = ((idx_b - idx_a) mod NREG) + 1, giving a range of 1 to 32.
- Wrap-around: if idx_b < idx_a, the index runs idx_a..31, then 0..idx_b. Example: a=30, b=1 gives 30, 31, 0, 1.
- Equal indices: idx_a == idx_b in sweep mode behaves exactly like single mode (one ISSUE cycle).
- Full range: a=0, b=31 gives 32 ISSUE cycles.
- DONE:
  - en_out=0, done=1 for one cycle, busy=1.
  - Next state is IDLE, unconditionally.
- abort:
  - In ISSUE or DONE, abort=1 forces IDLE on the next edge: en_out=0, done=0, busy=0.
  - abort has priority over every other transition.
  - In IDLE, abort has priority over start: start is ignored in that cycle.
- Inputs while busy: start, sweep, idx_a and idx_b are ignored while busy=1. Changing them mid-operation has no effect.
- Back-to-back: start may be asserted in the cycle the block is back in IDLE. The earliest next ISSUE is then the cycle after that.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- start is sampled at edge 0; en_out shows the first one-hot value after edge 0 (cycle 1).
- Single mode:
  - cycle 1: ISSUE
  - cycle 2: DONE (done=1)
  - cycle 3: IDLE
  - Total latency from start to done is 2 cycles.
- Sweep of N indices:
  - ISSUE cycles 1..N
  - DONE in cycle N+1
  - IDLE in cycle N+2
- busy is high from cycle 1 through the DONE cycle inclusive.
- idx_out changes only on ISSUE cycles.
- Reset mid-operation: outputs clear immediately on reset_n falling, without waiting for a clock edge. The first start is accepted on the first clock edge after reset_n rises.

## Test plan
- Reset: hold reset_n=0 with start=1. Required: en_out=0, busy=0, done=0 and idx_out=0 throughout. After release, with start=0, the block stays in IDLE.
- Single mode, all indices: start with sweep=0 for each idx_a from 0 to 31. Required:
  - exactly one ISSUE cycle with en_out = 1<<idx_a and idx_out = idx_a;
  - done one cycle later;
  - e.g. idx_a=12 gives en_out=32'h0000_1000, and idx_a=31 gives en_out=32'h8000_0000.
- Sweep, no wrap: a=3, b=6. Required: en_out sequence 32'h08, 32'h10, 32'h20, 32'h40 on consecutive cycles, then a DONE cycle with en_out=0 and done=1.
- Sweep with wrap: a=30, b=1. Required: idx_out sequence 30, 31, 0, 1, then done. Also a=0, b=31 gives 32 ISSUE cycles; a=b=9 gives one ISSUE cycle with 32'h200.
- Abort and ignored inputs:
  - Sweep a=0, b=31; assert abort in the 5th ISSUE cycle. Required: IDLE next cycle, en_out=0, no done pulse ever.
  - While busy, toggle start and change idx_a. Required: the running sequence is unaffected.
- Reset mid-sweep: drive reset_n low asynchronously during ISSUE. Required: en_out=0 and busy=0 before the next clock edge. A new single start with idx_a=7 after release gives en_out=32'h80.
